// File: rtl/edge_event_logger.sv
// edge_event_logger: turns rising edges of a synchronized level into
// timestamped events with re-trigger lockout, queued in a small
// first-word-fall-through FIFO behind a valid/ready handshake.
module edge_event_logger #(
    parameter int TS_WIDTH   = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int LOCKOUT    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_async,
    input  logic                 sync_in,
    input  logic                 clear_ovf,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [TS_WIDTH-1:0]  ev_ts,
    output logic [CNT_WIDTH-1:0] ev_count,
    output logic                 overflow,
    output logic                 busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
    // Counter is loaded with LOCKOUT-1 so busy spans exactly LOCKOUT cycles.
    localparam logic [LW-1:0] LOCK_INIT = LW'((LOCKOUT > 0) ? LOCKOUT - 1 : 0);
    localparam logic [PW:0]   OCC_FULL  = (PW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t              state, state_next;
    logic [LW-1:0]       lock_cnt, lock_next;
    logic [TS_WIDTH-1:0] ts;
    logic                prev;
    logic                rise;
    logic                trigger;

    logic [TS_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic [PW:0]         occ;
    logic                full, pop, push, drop;

    // prev resets low, so a level held high through reset release reads as a rise.
    assign rise = sync_in & ~prev;

    // Free-running timestamp and edge-detect history.
    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            ts   <= '0;
            prev <= 1'b0;
        end else begin
            ts   <= ts + 1'b1;
            prev <= sync_in;
        end
    end

    // Lockout FSM state register.
    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            state    <= IDLE;
            lock_cnt <= '0;
        end else begin
            state    <= state_next;
            lock_cnt <= lock_next;
        end
    end

    // Lockout FSM: accept rises only in IDLE, then hold off for LOCKOUT cycles.
    always_comb begin
        state_next = state;
        lock_next  = lock_cnt;
        trigger    = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    trigger = 1'b1;
                    if (LOCKOUT > 0) begin
                        state_next = LOCK;
                        lock_next  = LOCK_INIT;
                    end
                end
            end
            LOCK: begin
                busy = 1'b1;
                if (lock_cnt == '0) state_next = IDLE;
                else                lock_next  = lock_cnt - 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // A full queue still takes a push when the head leaves on the same edge.
    assign full     = (occ == OCC_FULL);
    assign ev_valid = (occ != '0);
    assign pop      = ev_valid & ev_ready;
    assign push     = trigger & (~full | pop);
    assign drop     = trigger & full & ~pop;
    assign ev_ts    = mem[rd_ptr];

    // Queue storage; contents are meaningless unless occupancy covers them.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ts;
    end

    // Queue pointers, occupancy, event counter and sticky overflow.
    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            ev_count <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                ev_count <= ev_count + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)           overflow <= 1'b1;
            else if (clear_ovf) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_edge_event_logger.sv
// Randomized bench for edge_event_logger: a cycle-level reference model
// derives expected events from the edge/lockout/queue rules, a scoreboard
// queue holds expected timestamps, and a monitor checks every handshake.
module tb_edge_event_logger;

    localparam int TSW = 16;
    localparam int CW  = 8;
    localparam int L   = 8;
    localparam int D   = 4;

    logic           clk = 1'b0;
    logic           reset_async = 1'b1;
    logic           sync_in = 1'b0;
    logic           clear_ovf = 1'b0;
    logic           ev_ready = 1'b0;
    logic           ev_valid;
    logic [TSW-1:0] ev_ts;
    logic [CW-1:0]  ev_count;
    logic           overflow;
    logic           busy;

    edge_event_logger #(.TS_WIDTH(TSW), .CNT_WIDTH(CW), .LOCKOUT(L), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset_async(reset_async), .sync_in(sync_in), .clear_ovf(clear_ovf),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ts(ev_ts), .ev_count(ev_count),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: edge index since reset, time of last accepted trigger,
    // queue occupancy, event count, overflow flag, previous sampled level.
    int             m_n, m_last, m_occ, m_cnt;
    bit             m_prev, m_ovf;
    logic [TSW-1:0] sb[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        return (m_n - 1 - m_last) < L;
    endfunction

    task automatic model_reset();
        m_n = 0; m_last = -1000; m_occ = 0; m_cnt = 0;
        m_prev = 1'b0; m_ovf = 1'b0;
        sb.delete();
    endtask

    // One clock edge of the reference, using inputs held across the edge.
    task automatic model_step();
        bit pop, rise, trig, drop;
        pop  = (m_occ > 0) && ev_ready;
        rise = sync_in && !m_prev;
        trig = rise && !m_busy();
        drop = 1'b0;
        if (trig) begin
            if (m_occ < D || pop) begin
                sb.push_back(TSW'(m_n));
                m_occ++;
                m_cnt = (m_cnt + 1) % (1 << CW);
            end else begin
                drop = 1'b1;
            end
            m_last = m_n;
        end
        if (pop) m_occ--;
        if (drop)           m_ovf = 1'b1;
        else if (clear_ovf) m_ovf = 1'b0;
        m_prev = sync_in;
        m_n++;
    endtask

    // Monitor: state flags every cycle, head timestamp on every handshake.
    initial begin
        forever begin
            @(negedge clk);
            check("ev_valid", int'(ev_valid), int'(m_occ > 0));
            check("ev_count", int'(ev_count), m_cnt);
            check("overflow", int'(overflow), int'(m_ovf));
            check("busy", int'(busy), int'(m_busy()));
            if (ev_valid && ev_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_pop", 1, 0);
                end else begin
                    check("ev_ts", int'(ev_ts), int'(sb.pop_front()));
                end
            end
        end
    end

    // Phase table: toggle %, ready %, clear %, length in cycles.
    int ph_tog[6] = '{30, 35, 50, 40, 20, 45};
    int ph_rdy[6] = '{100, 0, 100, 20, 70, 50};
    int ph_clr[6] = '{0, 0, 5, 10, 2, 20};
    int ph_len[6] = '{300, 200, 300, 400, 400, 300};

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_async = 1'b0;
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < ph_len[p]; c++) begin
                @(posedge clk);
                model_step();
                #1;
                if ($urandom_range(99) < ph_tog[p]) sync_in = ~sync_in;
                ev_ready  = ($urandom_range(99) < ph_rdy[p]);
                clear_ovf = ($urandom_range(99) < ph_clr[p]);
            end
            // Asynchronous reset between edges: outputs must clear at once.
            reset_async = 1'b1;
            #1;
            model_reset();
            check("rst_valid", int'(ev_valid), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_count", int'(ev_count), 0);
            check("rst_ovf", int'(overflow), 0);
            repeat (2) @(posedge clk);
            // Release with the level already high: first edge must log ts=0.
            #1;
            sync_in     = 1'b1;
            ev_ready    = 1'b0;
            clear_ovf   = 1'b0;
            reset_async = 1'b0;
            @(posedge clk);
            model_step();
            #1;
            check("rel_head", int'(sb.size()), 1);
            @(negedge clk);
            check("rel_ts", int'(ev_ts), 0);
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/edge_event_logger.md
Name: edge_event_logger

Overview:
- Consumes the clk-domain level produced by the asynchronous edge-capture stage (high from capture until the async source falls).
- Converts each rising edge of that level into one timestamped event, with a programmable lockout (re-trigger suppression).
- Queues events in a small FIFO and presents them on a valid/ready interface to the downstream consumer (register bank or bus bridge).

Parameters:
- TS_WIDTH, 16: width of the free-running timestamp counter and of ev_ts.
- CNT_WIDTH, 8: width of the accepted-event counter.
- LOCKOUT, 8: clk cycles after an accepted event during which new rising edges are ignored. 0 = no lockout.
- FIFO_DEPTH, 4: event queue depth. Must be a power of 2, ≥2.

Ports:
- clk  in  1  system clock.
- reset_async  in  1  reset, asynchronous, active-high.
- sync_in  in  1  synchronized level from the edge-capture stage; already registered in the clk domain.
- clear_ovf  in  1  one-cycle strobe that clears overflow.
- ev_valid  out  1  FIFO not empty.
- ev_ready  in  1  consumer accepts the head entry.
- ev_ts  out  TS_WIDTH  timestamp of the head entry; don't-care when ev_valid=0.
- ev_count  out  CNT_WIDTH  number of events pushed into the FIFO; wraps modulo 2^CNT_WIDTH.
- overflow  out  1  sticky flag: an event was dropped because the FIFO was full.
- busy  out  1  lockout active.

Behaviour:
- Reset: reset_async=1 clears everything immediately, with no clock edge required.
  - Cleared state: ts, prev, FIFO pointers and occupancy, ev_count, overflow, lockout counter; FSM to IDLE.
  - Resulting outputs: ev_valid=0, busy=0, overflow=0, ev_count=0.
- Timestamp: ts increments by 1 every clk edge and wraps at 2^TS_WIDTH.
- Edge detect:
  - prev <= sync_in every edge.
  - rise = sync_in & ~prev (combinational).
  - A sync_in held high across reset release counts as a rise at the first edge.
- FSM IDLE:
  - On rise, the event is "triggered" at that edge: the current ts value (before increment) is the event timestamp.
  - If LOCKOUT>0, go to LOCK and load the lockout counter with LOCKOUT-1.
- FSM LOCK:
  - busy=1.
  - Rises are ignored (not counted, not flagged).
  - The counter decrements each edge; at 0 return to IDLE.
  - busy is high for exactly LOCKOUT cycles after the trigger edge.
  - A rise in the first IDLE cycle after LOCK is accepted.
- Push on trigger:
  - FIFO not full: write the timestamp and increment ev_count. ev_valid is high from the cycle after the trigger edge (latency 1).
  - FIFO full and no pop this cycle: drop the event, set overflow, leave ev_count unchanged.
  - FIFO full with a simultaneous pop (ev_valid & ev_ready): the push is accepted and overflow is not set.
- Pop:
  - Occurs when ev_valid & ev_ready at an edge; the head advances and ev_ts shows the next entry in the next cycle.
  - The FIFO is first-word-fall-through: ev_ts is valid in the same cycle as ev_valid.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy 0..FIFO_DEPTH.
  - Push and pop on the same edge leave occupancy unchanged.
- Overflow flag:
  - clear_ovf clears overflow at the next edge.
  - If a drop occurs in the same cycle as clear_ovf, set wins: overflow stays 1.
- Reset mid-operation: pending FIFO entries are discarded and no partial event survives.

Test Plan (LOCKOUT=8, FIFO_DEPTH=4, TS_WIDTH=16):
1. Basic event: release reset; sync_in high for 3 cycles starting when ts=10; ev_ready=1.
   -> ev_valid high for exactly 1 cycle, starting the cycle after the trigger edge.
   -> ev_ts=10, ev_count=1, busy high for 8 cycles, overflow=0.
2. Lockout: rises at ts=20 and ts=25.
   -> One event (ev_ts=20); ev_count increments by 1.
   Then rises at ts=40 and ts=49.
   -> Two events, ev_ts=40 and 49.
3. Overflow: ev_ready=0; 5 rises spaced 12 cycles from ts=100.
   -> FIFO holds 100, 112, 124, 136; the 5th sets overflow=1; ev_count=4.
   Then ev_ready=1.
   -> ev_ts sequence 100, 112, 124, 136 on consecutive cycles, then ev_valid=0.
4. Full plus simultaneous pop: FIFO full, a trigger on the same edge as ev_ready=1.
   -> No overflow; ev_count increments; occupancy stays 4; new timestamp appears last in order.
5. Overflow clear: clear_ovf with no drop -> overflow=0 next cycle. clear_ovf in the same cycle as a drop -> overflow remains 1.
6. Async reset: assert reset_async mid-LOCK with 3 entries queued and no clock edge.
   -> busy=0, ev_valid=0, ev_count=0 immediately.
   Release with sync_in held high.
   -> One event at the first edge, ev_ts=0.
